control_sequencer: RTL and testbench

Two-state instruction fetch/execute sequencer that sits directly upstream of the register-file/ALU/RAM datapath. It holds the program counter and instruction register, decodes each 32-bit instruction into the datapath's 24-bit control word and 64-bit constant `K`, and uses the datapath's returned ALU status to resolve conditional branches. Every instruction takes exactly two clock cycles, FETCH then EXEC.

---
 rtl/control_sequencer.sv | 158 +++++++++++++++
 tb/tb_control_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : control_sequencer
//  Purpose  : Two-state (FETCH/EXEC) instruction sequencer. Holds the PC and
//             the instruction register. Decodes each 32-bit instruction into
//             a 24-bit datapath control word and a 64-bit constant K, and
//             resolves conditional branches from the live ALU status flags.
//  Ports    : clock       - rising-edge clock
//             reset       - asynchronous, active-low reset
//             instr       - instruction word at pc (combinational imem)
//             status      - ALU flags {V, C, N, Z}
//             pc          - word address of the current instruction
//             controlWord - {DA, SA, SB, FS, regW, ramW, selALU, selK}
//             K           - constant for the datapath B-mux
//             halted      - high while in the HALT state
//  Revision : 1.0 - initial release
// ============================================================================
module control_sequencer #(
   parameter logic [63:0] RESET_PC = 64'd0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic [3:0]  status,
   output logic [63:0] pc,
   output logic [23:0] controlWord,
   output logic [63:0] K,
   output logic        halted
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam logic [3:0] OP_ALU_R  = 4'h1;
   localparam logic [3:0] OP_ALU_I  = 4'h2;
   localparam logic [3:0] OP_LOAD   = 4'h3;
   localparam logic [3:0] OP_STORE  = 4'h4;
   localparam logic [3:0] OP_BRANCH = 4'h5;
   localparam logic [3:0] OP_JUMP   = 4'h6;
   localparam logic [3:0] OP_HALT   = 4'hF;

   state_t      state;
   logic [31:0] ir;

   // Fields of the incoming instruction (decoded at the FETCH edge)
   logic [3:0]  op;
   logic [4:0]  fs, da, sa, sb;
   logic [12:0] imm13;
   logic [7:0]  imm8;

   assign op    = instr[31:28];
   assign fs    = instr[27:23];
   assign da    = instr[22:18];
   assign sa    = instr[17:13];
   assign sb    = instr[12:8];
   assign imm13 = instr[12:0];
   assign imm8  = instr[7:0];

   // Only Z and N take part in branch conditions
   logic unused_status;
   assign unused_status = ^status[3:2];

   logic [23:0] dec_cw;
   logic [63:0] dec_k;

   // Low nibble of the control word is {regW, ramW, selALU, selK}
   always_comb begin
      dec_cw = 24'd0;
      dec_k  = 64'd0;
      case (op)
         OP_ALU_R:  dec_cw = {da, sa, sb, fs, 4'b1010};
         OP_ALU_I: begin
            dec_cw = {da, sa, 5'd0, fs, 4'b1011};
            dec_k  = {{51{imm13[12]}}, imm13};
         end
         OP_LOAD: begin
            dec_cw = {da, sa, 5'd0, fs, 4'b1001};
            dec_k  = {{51{imm13[12]}}, imm13};
         end
         OP_STORE: begin
            dec_cw = {5'd0, sa, sb, fs, 4'b0101};
            dec_k  = {{56{imm8[7]}}, imm8};
         end
         OP_BRANCH: dec_cw = {5'd0, sa, sb, fs, 4'b0000};
         default: begin
            dec_cw = 24'd0;
            dec_k  = 64'd0;
         end
      endcase
   end

   // Branch resolution uses the latched IR and the status seen at the EXEC edge
   logic        taken;
   logic [63:0] pc_inc;
   logic [63:0] next_pc;

   always_comb begin
      case (ir[19:18])
         2'd0:    taken = status[0];
         2'd1:    taken = ~status[0];
         2'd2:    taken = status[1];
         default: taken = ~status[1];
      endcase
   end

   assign pc_inc = pc + 64'd1;

   always_comb begin
      next_pc = pc_inc;
      if (ir[31:28] == OP_BRANCH && taken)
         next_pc = pc_inc + {{56{ir[7]}}, ir[7:0]};
      else if (ir[31:28] == OP_JUMP)
         next_pc = {36'd0, ir[27:0]};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_FETCH;
         ir          <= 32'd0;
         pc          <= RESET_PC;
         controlWord <= 24'd0;
         K           <= 64'd0;
         halted      <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               ir          <= instr;
               controlWord <= dec_cw;
               K           <= dec_k;
               if (op == OP_HALT) begin
                  state  <= ST_HALT;
                  halted <= 1'b1;
               end else begin
                  state  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               controlWord <= 24'd0;
               K           <= 64'd0;
               pc          <= next_pc;
               state       <= ST_FETCH;
            end
            ST_HALT: begin
               // Sticky until reset; pc keeps the HALT instruction's address
               controlWord <= 24'd0;
               K           <= 64'd0;
               halted      <= 1'b1;
            end
            default: state <= ST_FETCH;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_sequencer
//  Purpose  : Self-checking bench for control_sequencer. Directed instruction
//             vectors push hand-computed expected outputs into a queue; a
//             monitor pops one entry after every rising edge and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instr = 32'h1234_5678;
   logic [3:0]  status = 4'd0;
   logic [63:0] pc;
   logic [23:0] controlWord;
   logic [63:0] K;
   logic        halted;

   // Second instance for the PC wrap case
   logic        reset2 = 1'b0;
   logic [31:0] instr2 = 32'd0;
   logic [3:0]  status2 = 4'd0;
   logic [63:0] pc2;
   logic [23:0] cw2;
   logic [63:0] k2;
   logic        halted2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] pc;
      logic [23:0] cw;
      logic [63:0] k;
      logic        h;
   } exp_t;

   exp_t exp_q[$];

   always #5 clock = ~clock;

   control_sequencer dut (
      .clock(clock), .reset(reset), .instr(instr), .status(status),
      .pc(pc), .controlWord(controlWord), .K(K), .halted(halted)
   );

   control_sequencer #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFF)) dut_wrap (
      .clock(clock), .reset(reset2), .instr(instr2), .status(status2),
      .pc(pc2), .controlWord(cw2), .K(k2), .halted(halted2)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [23:0] mk_cw(input int da, input int sa, input int sb,
                                         input int fs, input logic [3:0] en);
      mk_cw = {da[4:0], sa[4:0], sb[4:0], fs[4:0], en};
   endfunction

   // Called between edges: drives one cycle's inputs and records the
   // outputs expected after the following rising edge.
   task automatic cyc(input logic [31:0] i, input logic [3:0] s, input logic [63:0] epc,
                      input logic [23:0] ecw, input logic [63:0] ek, input logic eh);
      exp_t e;
      instr = i;
      status = s;
      e.pc = epc; e.cw = ecw; e.k = ek; e.h = eh;
      exp_q.push_back(e);
      @(posedge clock);
      #2;
   endtask

   // Monitor
   int n_mon = 0;
   always @(posedge clock) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk($sformatf("cyc%0d_pc", n_mon), pc, e.pc);
         chk($sformatf("cyc%0d_cw", n_mon), {40'd0, controlWord}, {40'd0, e.cw});
         chk($sformatf("cyc%0d_K", n_mon), K, e.k);
         chk($sformatf("cyc%0d_halted", n_mon), {63'd0, halted}, {63'd0, e.h});
         n_mon++;
      end
   end

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   initial begin
      logic [23:0] cw_alur;
      cw_alur = mk_cw(7, 2, 9, 3, 4'b1010);

      // ---- reset held with an ALU_R on the bus ----
      instr = 32'h1123_4567;
      #23;
      chk("rst_pc", pc, 64'd0);
      chk("rst_cw", {40'd0, controlWord}, 64'd0);
      chk("rst_K", K, 64'd0);
      chk("rst_halted", {63'd0, halted}, 64'd0);
      chk("rst_wrap_pc", pc2, ONES);

      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk("release_cw", {40'd0, controlWord}, 64'd0);
      chk("release_pc", pc, 64'd0);

      // ---- directed program ----
      cyc(32'h2220_1FFF, 4'd0, 64'd0,  mk_cw(8, 0, 0, 4, 4'b1011), ONES, 1'b0); // ALU_I
      cyc(32'hF000_0000, 4'd0, 64'd1,  24'd0, 64'd0, 1'b0);                      // EXEC ignores instr
      cyc(32'h4000_6510, 4'd0, 64'd1,  mk_cw(0, 3, 5, 0, 4'b0101), 64'h10, 1'b0); // STORE
      cyc(32'h0,         4'd0, 64'd2,  24'd0, 64'd0, 1'b0);
      cyc(32'h6000_000A, 4'd0, 64'd2,  24'd0, 64'd0, 1'b0);                      // JUMP 10
      cyc(32'h0,         4'd0, 64'd10, 24'd0, 64'd0, 1'b0);
      cyc(32'h5000_01FC, 4'd0, 64'd10, mk_cw(0, 0, 1, 0, 4'b0000), 64'd0, 1'b0); // BR Z, -4
      cyc(32'h0,         4'd1, 64'd7,  24'd0, 64'd0, 1'b0);                      // Z=1 taken
      cyc(32'h6000_000A, 4'd0, 64'd7,  24'd0, 64'd0, 1'b0);
      cyc(32'h0,         4'd0, 64'd10, 24'd0, 64'd0, 1'b0);
      cyc(32'h5000_01FC, 4'd1, 64'd10, mk_cw(0, 0, 1, 0, 4'b0000), 64'd0, 1'b0); // status ignored in FETCH
      cyc(32'h0,         4'd0, 64'd11, 24'd0, 64'd0, 1'b0);                      // Z=0 not taken
      cyc(32'h5004_00FF, 4'd1, 64'd11, 24'd0, 64'd0, 1'b0);                      // BR !Z, to self
      cyc(32'h0,         4'd0, 64'd11, 24'd0, 64'd0, 1'b0);
      cyc(32'h500C_00FF, 4'd0, 64'd11, 24'd0, 64'd0, 1'b0);                      // BR !N
      cyc(32'h0,         4'd2, 64'd12, 24'd0, 64'd0, 1'b0);                      // N=1 not taken
      cyc(32'h5008_0002, 4'd0, 64'd12, 24'd0, 64'd0, 1'b0);                      // BR N, +2
      cyc(32'h0,         4'd2, 64'd15, 24'd0, 64'd0, 1'b0);
      cyc(32'h119C_4900, 4'd0, 64'd15, cw_alur, 64'd0, 1'b0);                    // ALU_R
      cyc(32'h0,         4'd0, 64'd16, 24'd0, 64'd0, 1'b0);
      cyc(32'h3004_8123, 4'd0, 64'd16, mk_cw(1, 4, 0, 0, 4'b1001), 64'h123, 1'b0); // LOAD
      cyc(32'h0,         4'd0, 64'd17, 24'd0, 64'd0, 1'b0);
      cyc(32'h9FFF_FFFF, 4'd0, 64'd17, 24'd0, 64'd0, 1'b0);                      // undefined op
      cyc(32'h0,         4'd0, 64'd18, 24'd0, 64'd0, 1'b0);
      cyc(32'h6000_0040, 4'd0, 64'd18, 24'd0, 64'd0, 1'b0);                      // JUMP 0x40
      cyc(32'h0,         4'd0, 64'h40, 24'd0, 64'd0, 1'b0);
      cyc(32'hF000_0000, 4'd0, 64'h40, 24'd0, 64'd0, 1'b1);                      // HALT
      for (int i = 0; i < 20; i++)
         cyc(32'h119C_4900, 4'd1, 64'h40, 24'd0, 64'd0, 1'b1);

      // ---- reset pulse leaves HALT ----
      reset = 1'b0;
      #1;
      chk("halt_rst_pc", pc, 64'd0);
      chk("halt_rst_halted", {63'd0, halted}, 64'd0);
      #1;
      reset = 1'b1;

      // ---- asynchronous reset during an ALU_R EXEC ----
      cyc(32'h119C_4900, 4'd0, 64'd0, cw_alur, 64'd0, 1'b0);
      #3;
      reset = 1'b0;
      #1;
      chk("midexec_regW", {63'd0, controlWord[3]}, 64'd0);
      chk("midexec_cw", {40'd0, controlWord}, 64'd0);
      chk("midexec_pc", pc, 64'd0);
      @(posedge clock);
      #2;
      reset = 1'b1;
      cyc(32'h0, 4'd0, 64'd0, 24'd0, 64'd0, 1'b0);
      cyc(32'h0, 4'd0, 64'd1, 24'd0, 64'd0, 1'b0);

      // ---- PC wrap from 2^64-1 with a NOP ----
      reset2 = 1'b1;
      @(posedge clock);
      #1;
      chk("wrap_fetch_pc", pc2, ONES);
      chk("wrap_fetch_cw", {40'd0, cw2}, 64'd0);
      @(posedge clock);
      #1;
      chk("wrap_exec_pc", pc2, 64'd0);
      chk("wrap_halted", {63'd0, halted2}, 64'd0);

      // Every queued expectation must have been consumed
      repeat (2) @(posedge clock);
      #2;
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
